// File: rtl/branch_commit_unit.sv
// branch_commit_unit: in-order branch tracker on the ROB side.
// It records issued branches (predictor tag and predicted direction) and accepts
// out-of-order ALU resolutions. It retires branches in program order, updates the
// predictor on each retirement and flushes with the corrected PC on a mispredict.
// Optional build macro BCU_STATS_EN adds the commit and mispredict counter outputs.
module branch_commit_unit #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              in_alloc_valid,
   input  logic [TAG_W-1:0]  in_alloc_tag,
   input  logic              in_alloc_pred,
   output logic [IDX_W-1:0]  out_alloc_idx,
   output logic              out_full,
   input  logic              in_resolve_valid,
   input  logic [IDX_W-1:0]  in_resolve_idx,
   input  logic              in_resolve_taken,
   input  logic [ADDR_W-1:0] in_resolve_pc,
   output logic              out_bp_res,
   output logic [TAG_W-1:0]  out_bp_tag,
   output logic              out_bp_jump_res,
   output logic              out_flush,
   output logic [ADDR_W-1:0] out_flush_pc
`ifdef BCU_STATS_EN
   ,
   output logic [31:0]       out_stat_commits,
   output logic [31:0]       out_stat_mispred
`endif
);

   localparam int unsigned CNT_W = IDX_W + 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [DEPTH-1:0]  valid_q, resolved_q, pred_q, taken_q;
   logic [TAG_W-1:0]  tag_q [DEPTH];
   logic [ADDR_W-1:0] pc_q  [DEPTH];
   logic [IDX_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;

   logic commit_c, mispred_c, alloc_c, resolve_c;

   // Allocation is refused when the ring is full or while the pipe refetches.
   assign out_full      = (count_q == CNT_W'(DEPTH)) || (state_q == FLUSH);
   assign out_alloc_idx = tail_q;

   // Per-cycle decode of commit/resolve/allocate events and next-state logic.
   always_comb begin
      state_d   = state_q;
      commit_c  = 1'b0;
      mispred_c = 1'b0;
      alloc_c   = 1'b0;
      resolve_c = 1'b0;

      commit_c  = rdy && (state_q == RUN) && valid_q[head_q] && resolved_q[head_q];
      mispred_c = commit_c && (taken_q[head_q] != pred_q[head_q]);
      // A mispredict squashes everything, including a same-cycle allocation.
      alloc_c   = rdy && in_alloc_valid && !out_full && !mispred_c;
      resolve_c = rdy && in_resolve_valid && (state_q == RUN) && valid_q[in_resolve_idx];

      case (state_q)
         RUN:     if (mispred_c) state_d = FLUSH;
         FLUSH:   if (rdy)       state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Entry storage, ring pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         resolved_q <= '0;
         pred_q     <= '0;
         taken_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
            pc_q[i]  <= '0;
         end
      end else begin
         if (resolve_c) begin
            resolved_q[in_resolve_idx] <= 1'b1;
            taken_q[in_resolve_idx]    <= in_resolve_taken;
            pc_q[in_resolve_idx]       <= in_resolve_pc;
         end
         if (alloc_c) begin
            valid_q[tail_q]    <= 1'b1;
            resolved_q[tail_q] <= 1'b0;
            tag_q[tail_q]      <= in_alloc_tag;
            pred_q[tail_q]     <= in_alloc_pred;
            tail_q             <= tail_q + IDX_W'(1);
         end
         if (commit_c) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + IDX_W'(1);
         end
         count_q <= count_q + CNT_W'(alloc_c) - CNT_W'(commit_c);
         if (mispred_c) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end
      end
   end

   // Registered predictor-update and flush outputs; pulses clear on idle rdy cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_bp_res      <= 1'b0;
         out_bp_tag      <= '0;
         out_bp_jump_res <= 1'b0;
         out_flush       <= 1'b0;
         out_flush_pc    <= '0;
      end else if (rdy) begin
         out_bp_res <= commit_c;
         out_flush  <= mispred_c;
         if (commit_c) begin
            out_bp_tag      <= tag_q[head_q];
            out_bp_jump_res <= taken_q[head_q];
         end
         if (mispred_c) out_flush_pc <= pc_q[head_q];
      end
   end

`ifdef BCU_STATS_EN
   // Free-running commit and mispredict counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_stat_commits <= '0;
         out_stat_mispred <= '0;
      end else begin
         if (commit_c)  out_stat_commits <= out_stat_commits + 32'd1;
         if (mispred_c) out_stat_mispred <= out_stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_commit_unit.sv
// Scoreboard bench for branch_commit_unit: expected commits are queued when the
// resolving stimulus is driven and popped as predictor-update pulses appear.
module tb_branch_commit_unit;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned ADDR_W = 32;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic              jump;
      logic              flush;
      logic [ADDR_W-1:0] pc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst, rdy;
   logic              in_alloc_valid, in_alloc_pred;
   logic [TAG_W-1:0]  in_alloc_tag;
   logic [IDX_W-1:0]  out_alloc_idx;
   logic              out_full;
   logic              in_resolve_valid, in_resolve_taken;
   logic [IDX_W-1:0]  in_resolve_idx;
   logic [ADDR_W-1:0] in_resolve_pc;
   logic              out_bp_res, out_bp_jump_res, out_flush;
   logic [TAG_W-1:0]  out_bp_tag;
   logic [ADDR_W-1:0] out_flush_pc;
`ifdef BCU_STATS_EN
   logic [31:0]       out_stat_commits, out_stat_mispred;
`endif

   int   total = 0;
   int   bad   = 0;
   int   pulses = 0;
   exp_t exp_q[$];
   exp_t e;
   logic rdy_at_edge = 1'b0;

   branch_commit_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .in_alloc_valid(in_alloc_valid), .in_alloc_tag(in_alloc_tag), .in_alloc_pred(in_alloc_pred),
      .out_alloc_idx(out_alloc_idx), .out_full(out_full),
      .in_resolve_valid(in_resolve_valid), .in_resolve_idx(in_resolve_idx),
      .in_resolve_taken(in_resolve_taken), .in_resolve_pc(in_resolve_pc),
      .out_bp_res(out_bp_res), .out_bp_tag(out_bp_tag), .out_bp_jump_res(out_bp_jump_res),
      .out_flush(out_flush), .out_flush_pc(out_flush_pc)
`ifdef BCU_STATS_EN
      , .out_stat_commits(out_stat_commits), .out_stat_mispred(out_stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      check("rst_bp_res", 64'(out_bp_res), 64'd0);
      check("rst_flush", 64'(out_flush), 64'd0);
      check("rst_full", 64'(out_full), 64'd0);
      check("rst_idx", 64'(out_alloc_idx), 64'd0);
      check("rst_tag", 64'(out_bp_tag), 64'd0);
      check("rst_jump", 64'(out_bp_jump_res), 64'd0);
      check("rst_fpc", 64'(out_flush_pc), 64'd0);
   endtask

   task automatic alloc(input logic [TAG_W-1:0] tag, input logic pred);
      in_alloc_valid = 1'b1;
      in_alloc_tag   = tag;
      in_alloc_pred  = pred;
      step();
      in_alloc_valid = 1'b0;
   endtask

   task automatic resolve(input logic [IDX_W-1:0] idx, input logic taken, input logic [ADDR_W-1:0] pc);
      in_resolve_valid = 1'b1;
      in_resolve_idx   = idx;
      in_resolve_taken = taken;
      in_resolve_pc    = pc;
      step();
      in_resolve_valid = 1'b0;
   endtask

   // Records whether the DUT saw rdy high (and no reset) at each edge.
   always @(posedge clk) rdy_at_edge <= rdy && !rst;

   // Commit monitor: each fresh update pulse is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rdy_at_edge && out_bp_res) begin
            pulses++;
            if (exp_q.size() == 0) begin
               check("unexpected_commit", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("bp_tag", 64'(out_bp_tag), 64'(e.tag));
               check("bp_jump", 64'(out_bp_jump_res), 64'(e.jump));
               check("bp_flush", 64'(out_flush), 64'(e.flush));
               if (e.flush) check("flush_pc", 64'(out_flush_pc), 64'(e.pc));
            end
         end else if (rdy_at_edge && out_flush) begin
            check("orphan_flush", 64'd1, 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      logic [IDX_W-1:0] idx;
      rst = 1'b1; rdy = 1'b1;
      in_alloc_valid = 1'b0; in_alloc_tag = '0; in_alloc_pred = 1'b0;
      in_resolve_valid = 1'b0; in_resolve_idx = '0; in_resolve_taken = 1'b0; in_resolve_pc = '0;
      step();
      do_reset();

      // Single correctly predicted branch; pulse two edges after resolve presentation.
      alloc(8'h12, 1'b1);
      exp_q.push_back('{tag: 8'h12, jump: 1'b1, flush: 1'b0, pc: 32'h100});
      resolve(4'd0, 1'b1, 32'h100);
      check("t1_early", 64'(out_bp_res), 64'd0);
      step();
      check("t1_res", 64'(out_bp_res), 64'd1);
      check("t1_noflush", 64'(out_flush), 64'd0);
      step();
      check("t1_pulse_end", 64'(out_bp_res), 64'd0);

      // Out-of-order resolution still retires in program order.
      do_reset();
      alloc(8'h05, 1'b0);
      alloc(8'h06, 1'b1);
      p0 = pulses;
      resolve(4'd1, 1'b1, 32'h200);
      idle(4);
      check("t2_no_early", 64'(pulses - p0), 64'd0);
      exp_q.push_back('{tag: 8'h05, jump: 1'b0, flush: 1'b0, pc: 32'h204});
      exp_q.push_back('{tag: 8'h06, jump: 1'b1, flush: 1'b0, pc: 32'h200});
      resolve(4'd0, 1'b0, 32'h204);
      idle(4);
      check("t2_pulses", 64'(pulses - p0), 64'd2);

      // Mispredict: flush, one FLUSH cycle, same-cycle allocation dropped.
      idx = out_alloc_idx;
      alloc(8'hA0, 1'b1);
      exp_q.push_back('{tag: 8'hA0, jump: 1'b0, flush: 1'b1, pc: 32'h2004});
      resolve(idx, 1'b0, 32'h2004);
      in_alloc_valid = 1'b1; in_alloc_tag = 8'h77; in_alloc_pred = 1'b1;
      step();
      in_alloc_valid = 1'b0;
      check("t3_flush", 64'(out_flush), 64'd1);
      check("t3_fpc", 64'(out_flush_pc), 64'h2004);
      check("t3_jump", 64'(out_bp_jump_res), 64'd0);
      check("t3_full_flush", 64'(out_full), 64'd1);
      step();
      check("t3_full_after", 64'(out_full), 64'd0);
      check("t3_idx_after", 64'(out_alloc_idx), 64'd0);
      check("t3_flush_end", 64'(out_flush), 64'd0);
      p0 = pulses;
      resolve(4'd0, 1'b1, 32'h2100);
      idle(3);
      check("t3_dropped_alloc", 64'(pulses - p0), 64'd0);

      // Fill to capacity, refuse the extra allocation, then wrap the tail.
      for (int i = 0; i < 16; i++) alloc(8'(8'h30 + i), 1'b0);
      check("t4_full", 64'(out_full), 64'd1);
      alloc(8'h99, 1'b0);
      check("t4_drop_idx", 64'(out_alloc_idx), 64'd0);
      check("t4_still_full", 64'(out_full), 64'd1);
      exp_q.push_back('{tag: 8'h30, jump: 1'b0, flush: 1'b0, pc: 32'h300});
      resolve(4'd0, 1'b0, 32'h300);
      step();
      check("t4_not_full", 64'(out_full), 64'd0);
      check("t4_commit", 64'(out_bp_res), 64'd1);
      check("t4_wrap_idx", 64'(out_alloc_idx), 64'd0);
      alloc(8'h40, 1'b1);
      check("t4_next_idx", 64'(out_alloc_idx), 64'd1);
      check("t4_refull", 64'(out_full), 64'd1);
      do_reset();

      // Stalled rdy holds a pending commit; releasing it yields exactly one pulse.
      alloc(8'h55, 1'b1);
      exp_q.push_back('{tag: 8'h55, jump: 1'b1, flush: 1'b0, pc: 32'h500});
      resolve(4'd0, 1'b1, 32'h500);
      rdy = 1'b0;
      p0 = pulses;
      idle(5);
      check("t5_stall_pulses", 64'(pulses - p0), 64'd0);
      check("t5_stall_res", 64'(out_bp_res), 64'd0);
      rdy = 1'b1;
      idle(3);
      check("t5_release_pulses", 64'(pulses - p0), 64'd1);

      // Reset taken while in FLUSH with the flush pulse high.
      alloc(8'h66, 1'b0);
      exp_q.push_back('{tag: 8'h66, jump: 1'b1, flush: 1'b1, pc: 32'h600});
      resolve(4'd1, 1'b1, 32'h600);
      step();
      check("t6_flush", 64'(out_flush), 64'd1);
      @(negedge clk);
      do_reset();

`ifdef BCU_STATS_EN
      alloc(8'h01, 1'b1);
      alloc(8'h02, 1'b0);
      alloc(8'h03, 1'b1);
      exp_q.push_back('{tag: 8'h01, jump: 1'b1, flush: 1'b0, pc: 32'h10});
      exp_q.push_back('{tag: 8'h02, jump: 1'b0, flush: 1'b0, pc: 32'h20});
      exp_q.push_back('{tag: 8'h03, jump: 1'b0, flush: 1'b1, pc: 32'h30});
      resolve(4'd0, 1'b1, 32'h10);
      resolve(4'd1, 1'b0, 32'h20);
      resolve(4'd2, 1'b0, 32'h30);
      idle(4);
      check("stat_commits", 64'(out_stat_commits), 64'd3);
      check("stat_mispred", 64'(out_stat_mispred), 64'd1);
      do_reset();
      check("stat_commits_rst", 64'(out_stat_commits), 64'd0);
      check("stat_mispred_rst", 64'(out_stat_mispred), 64'd0);
`endif

      idle(2);
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
